// File: rtl/invader_formation_ctrl.sv
// Enemy formation sequencer: marches a row of enemies, drops/reverses at the edges, tracks kills.
// Optional SPEEDUP_EN: step period shortens by 3 frames per dead enemy (floor 2).
module invader_formation_ctrl #(
    parameter int unsigned N_ENEMIES       = 8,
    parameter int unsigned X_START         = 200,
    parameter int unsigned Y_START         = 50,
    parameter int unsigned SPACING         = 50,
    parameter int unsigned SPRITE_W        = 32,
    parameter int unsigned STEP_X          = 8,
    parameter int unsigned STEP_Y          = 16,
    parameter int unsigned X_MIN           = 0,
    parameter int unsigned X_MAX           = 640,
    parameter int unsigned Y_LIMIT         = 400,
    parameter int unsigned FRAMES_PER_STEP = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        kill_valid,
    input  logic [2:0]  kill_idx,
    output logic        kill_ack,
    output logic [7:0]  alive,
    output logic [79:0] pos_x,
    output logic [79:0] pos_y,
    output logic        step_pulse,
    output logic        dir_left,
    output logic        game_over,
    output logic        wave_clear
);

    localparam int unsigned CW = $clog2(FRAMES_PER_STEP + 1);
    localparam logic [7:0]  ALIVE_INIT = 8'((1 << N_ENEMIES) - 1);
    localparam logic [10:0] SP      = 11'(SPACING);
    localparam logic [10:0] R_EXTRA = 11'(SPRITE_W + STEP_X);
    localparam logic [10:0] L_LIM   = 11'(X_MIN + STEP_X);

    typedef enum logic [1:0] {MARCH, STEP, HALT} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   frame_cnt, cnt_n;
    logic [10:0]     base_x, base_y, bx_n, by_n;
    logic [7:0]      alive_n;
    logic            dir_n, ack_n, step_n, go_n, wc_n;
    logic            kill_hit;
    logic [2:0]      l_idx, r_idx;
    logic [10:0]     r_sum, l_sum;
    int unsigned     period;

    function automatic logic [79:0] pos_x_of(input logic [10:0] bx);
        logic [79:0] p;
        p = '0;
        for (int unsigned i = 0; i < N_ENEMIES; i++)
            p[i*10 +: 10] = 10'(bx + 11'(i * SPACING));
        return p;
    endfunction

    function automatic logic [79:0] pos_y_of(input logic [10:0] by);
        logic [79:0] p;
        p = '0;
        for (int unsigned i = 0; i < N_ENEMIES; i++)
            p[i*10 +: 10] = 10'(by);
        return p;
    endfunction

    // Edge indices come from the registered mask, so a same-cycle kill cannot shift the edge.
    always_comb begin
        l_idx = '0;
        r_idx = '0;
        for (int unsigned i = 0; i < 8; i++)
            if (alive[i]) r_idx = 3'(i);
        for (int unsigned i = 8; i > 0; i--)
            if (alive[i-1]) l_idx = 3'(i - 1);
        r_sum = base_x + 11'(r_idx) * SP + R_EXTRA;
        l_sum = base_x + 11'(l_idx) * SP;
    end

`ifdef SPEEDUP_EN
    int unsigned pop;
    int          p_raw;
    always_comb begin
        pop = 0;
        for (int unsigned i = 0; i < 8; i++)
            pop = pop + 32'(alive[i]);
        p_raw  = int'(FRAMES_PER_STEP) - 3 * (int'(N_ENEMIES) - int'(pop));
        period = (p_raw < 2) ? 2 : 32'(p_raw);
    end
`else
    always_comb period = FRAMES_PER_STEP;
`endif

    assign kill_hit = (state != HALT) && kill_valid &&
                      (32'(kill_idx) < N_ENEMIES) && alive[kill_idx];

    always_comb begin
        state_n = state;
        cnt_n   = frame_cnt;
        bx_n    = base_x;
        by_n    = base_y;
        dir_n   = dir_left;
        alive_n = alive;
        ack_n   = 1'b0;
        step_n  = 1'b0;
        go_n    = game_over;
        wc_n    = wave_clear;

        if (state != HALT) begin
            if (kill_hit) begin
                alive_n[kill_idx] = 1'b0;
                ack_n             = 1'b1;
            end
            if (alive == '0) begin
                state_n = HALT;
                wc_n    = 1'b1;
            end else begin
                case (state)
                    MARCH: begin
                        if (frame_tick) begin
                            if (32'(frame_cnt) + 1 >= period) begin
                                cnt_n   = '0;
                                state_n = STEP;
                            end else begin
                                cnt_n = frame_cnt + 1'b1;
                            end
                        end
                    end
                    STEP: begin
                        cnt_n   = frame_tick ? CW'(1) : '0;
                        step_n  = 1'b1;
                        state_n = MARCH;
                        if ((!dir_left && r_sum > 11'(X_MAX)) || (dir_left && l_sum < L_LIM)) begin
                            by_n  = base_y + 11'(STEP_Y);
                            dir_n = ~dir_left;
                        end else if (dir_left) begin
                            bx_n = base_x - 11'(STEP_X);
                        end else begin
                            bx_n = base_x + 11'(STEP_X);
                        end
                        if (by_n >= 11'(Y_LIMIT)) begin
                            go_n    = 1'b1;
                            state_n = HALT;
                        end
                    end
                    default: state_n = HALT;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= MARCH;
            frame_cnt  <= '0;
            base_x     <= 11'(X_START);
            base_y     <= 11'(Y_START);
            dir_left   <= 1'b0;
            alive      <= ALIVE_INIT;
            kill_ack   <= 1'b0;
            step_pulse <= 1'b0;
            game_over  <= 1'b0;
            wave_clear <= 1'b0;
            pos_x      <= pos_x_of(11'(X_START));
            pos_y      <= pos_y_of(11'(Y_START));
        end else begin
            state      <= state_n;
            frame_cnt  <= cnt_n;
            base_x     <= bx_n;
            base_y     <= by_n;
            dir_left   <= dir_n;
            alive      <= alive_n;
            kill_ack   <= ack_n;
            step_pulse <= step_n;
            game_over  <= go_n;
            wave_clear <= wc_n;
            pos_x      <= pos_x_of(bx_n);
            pos_y      <= pos_y_of(by_n);
        end
    end

endmodule

// File: tb/tb_invader_formation_ctrl.sv
// Directed self-checking bench for invader_formation_ctrl (FRAMES_PER_STEP=2, other params default).
module tb_invader_formation_ctrl;

    logic        clk = 1'b0;
    logic        reset, frame_tick, kill_valid;
    logic [2:0]  kill_idx;
    logic        kill_ack, step_pulse, dir_left, game_over, wave_clear;
    logic [7:0]  alive;
    logic [79:0] pos_x, pos_y;

    int checks = 0;
    int failures = 0;

    invader_formation_ctrl #(.FRAMES_PER_STEP(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .kill_valid (kill_valid),
        .kill_idx   (kill_idx),
        .kill_ack   (kill_ack),
        .alive      (alive),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .step_pulse (step_pulse),
        .dir_left   (dir_left),
        .game_over  (game_over),
        .wave_clear (wave_clear)
    );

    always #5 clk = ~clk;

    typedef struct {
        int steps;
        int x0;
        int x7;
        int y;
        int dir;
    } vec_t;

    vec_t tbl[7];

    function automatic int px(input int i);
        return int'(pos_x[i*10 +: 10]);
    endfunction

    function automatic int py(input int i);
        return int'(pos_y[i*10 +: 10]);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        frame_tick = 1'b0;
        kill_valid = 1'b0;
        kill_idx = '0;
        cyc();
        reset = 1'b0;
    endtask

    // Two ticks reach the step period; the new position is visible one cycle after STEP.
    task automatic do_step(output bit sp);
        frame_tick = 1'b1;
        cyc();
        cyc();
        frame_tick = 1'b0;
        cyc();
        sp = step_pulse;
    endtask

    task automatic kill(input int idx);
        kill_valid = 1'b1;
        kill_idx = 3'(idx);
        cyc();
        kill_valid = 1'b0;
    endtask

    initial begin
        bit sp;
        int acks;
        int pulses;

        tbl[0] = '{1, 208, 558, 50, 0};
        tbl[1] = '{6, 256, 606, 50, 0};
        tbl[2] = '{1, 256, 606, 66, 1};
        tbl[3] = '{1, 248, 598, 66, 1};
        tbl[4] = '{31,  0, 350, 66, 1};
        tbl[5] = '{1,   0, 350, 82, 0};
        tbl[6] = '{1,   8, 358, 82, 0};

        // Reset values
        apply_reset();
        chk("rst_x0", px(0), 200);
        chk("rst_x7", px(7), 550);
        chk("rst_y", py(3), 50);
        chk("rst_alive", int'(alive), 255);
        chk("rst_flags", int'({kill_ack, step_pulse, dir_left, game_over, wave_clear}), 0);

        // March table from reset
        for (int v = 0; v < 7; v++) begin
            for (int s = 0; s < tbl[v].steps; s++) do_step(sp);
            chk($sformatf("tbl%0d_pulse", v), int'(sp), 1);
            chk($sformatf("tbl%0d_x0", v), px(0), tbl[v].x0);
            chk($sformatf("tbl%0d_x7", v), px(7), tbl[v].x7);
            chk($sformatf("tbl%0d_y", v), py(7), tbl[v].y);
            chk($sformatf("tbl%0d_dir", v), int'(dir_left), tbl[v].dir);
        end
        cyc();
        chk("pulse_one_cycle", int'(step_pulse), 0);

        // frame_tick during STEP counts as the first tick of the next period
        apply_reset();
        frame_tick = 1'b1;
        cyc();
        cyc();
        cyc();
        chk("tickstep_pulse1", int'(step_pulse), 1);
        cyc();
        frame_tick = 1'b0;
        cyc();
        chk("tickstep_pulse2", int'(step_pulse), 1);
        chk("tickstep_x0", px(0), 216);

        // Killing the rightmost enemy moves the right edge
        apply_reset();
        kill(7);
        chk("k7_ack", int'(kill_ack), 1);
        chk("k7_alive", int'(alive), 8'h7F);
        for (int s = 0; s < 13; s++) do_step(sp);
        chk("k7_x0_304", px(0), 304);
        chk("k7_y_50", py(0), 50);
        do_step(sp);
        chk("k7_drop_y", py(0), 66);
        chk("k7_drop_dir", int'(dir_left), 1);
        chk("k7_drop_x0", px(0), 304);

        // Repeated kill of the same index acknowledges once
        apply_reset();
        acks = 0;
        kill_valid = 1'b1;
        kill_idx = 3'd3;
        cyc();
        acks += int'(kill_ack);
        cyc();
        acks += int'(kill_ack);
        kill_valid = 1'b0;
        cyc();
        acks += int'(kill_ack);
        chk("dup_kill_acks", acks, 1);
        chk("dup_kill_alive", int'(alive), 8'hF7);

        // Kill coincident with STEP: edge check uses the pre-kill mask
        apply_reset();
        for (int s = 0; s < 7; s++) do_step(sp);
        chk("coinc_pre_x0", px(0), 256);
        frame_tick = 1'b1;
        cyc();
        cyc();
        frame_tick = 1'b0;
        kill(7);
        chk("coinc_pulse", int'(step_pulse), 1);
        chk("coinc_ack", int'(kill_ack), 1);
        chk("coinc_y", py(0), 66);
        chk("coinc_dir", int'(dir_left), 1);
        chk("coinc_x0", px(0), 256);
        chk("coinc_alive", int'(alive), 8'h7F);

        // Wave clear
        apply_reset();
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            kill(i);
            acks += int'(kill_ack);
        end
        chk("wc_acks", acks, 8);
        chk("wc_alive", int'(alive), 0);
        chk("wc_not_yet", int'(wave_clear), 0);
        cyc();
        chk("wc_set", int'(wave_clear), 1);
        do_step(sp);
        do_step(sp);
        chk("wc_no_step", int'(sp), 0);
        chk("wc_x0_frozen", px(0), 200);
        chk("wc_sticky", int'(wave_clear), 1);

        // Game over: 22nd drop lands base_y at 402 on step 701
        apply_reset();
        pulses = 0;
        for (int s = 0; s < 800 && !game_over; s++) begin
            do_step(sp);
            pulses += int'(sp);
        end
        chk("go_flag", int'(game_over), 1);
        chk("go_steps", pulses, 701);
        chk("go_y", py(0), 402);
        chk("go_x0", px(0), 0);
        chk("go_dir", int'(dir_left), 0);
        do_step(sp);
        chk("halt_no_step", int'(sp), 0);
        chk("halt_y", py(0), 402);
        kill(2);
        chk("halt_kill_ack", int'(kill_ack), 0);
        chk("halt_alive", int'(alive), 255);

        // Mid-march reset
        apply_reset();
        for (int s = 0; s < 3; s++) do_step(sp);
        kill(1);
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        apply_reset();
        chk("mr_x0", px(0), 200);
        chk("mr_y", py(0), 50);
        chk("mr_alive", int'(alive), 255);
        chk("mr_flags", int'({kill_ack, step_pulse, dir_left, game_over, wave_clear}), 0);
        do_step(sp);
        chk("mr_first_step_x0", px(0), 208);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
